// File: rtl/pulp_io_l2_arbiter.sv
// Merges the uDMA ro/wo L2 ports onto one in-order L2 master port: rr or wo-priority arbitration,
// grant lock, and an ID FIFO that routes responses. Optional macro: PULP_IO_L2_ARB_WO_PRIO_EN.
module pulp_io_l2_arbiter #(
  parameter int L2_DATA_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_ni,
  input  logic                         ro_req_i,
  input  logic                         ro_wen_i,
  input  logic [31:0]                  ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     ro_wdata_i,
  output logic                         ro_gnt_o,
  output logic                         ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     ro_rdata_o,
  input  logic                         wo_req_i,
  input  logic                         wo_wen_i,
  input  logic [31:0]                  wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     wo_wdata_i,
  output logic                         wo_gnt_o,
  output logic                         wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     wo_rdata_o,
  output logic                         l2_req_o,
  output logic                         l2_wen_o,
  output logic [31:0]                  l2_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0]   l2_be_o,
  output logic [L2_DATA_WIDTH-1:0]     l2_wdata_o,
  input  logic                         l2_gnt_i,
  input  logic                         l2_rvalid_i,
  input  logic [L2_DATA_WIDTH-1:0]     l2_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                         err_o
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic            locked_sel;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            id_mem [MAX_OUTSTANDING];
  logic            err;
  logic            sel;        // 0 = ro, 1 = wo
  logic            sel_req;
  logic            throttled;
  logic            grant;
  logic            pop;
  logic            head;
  logic            conflict_pick;

`ifdef PULP_IO_L2_ARB_WO_PRIO_EN
  assign conflict_pick = 1'b1;
`else
  logic rr_wo;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_ni)
      rr_wo <= 1'b0;
    else if (grant)
      rr_wo <= ~sel;
  end

  assign conflict_pick = rr_wo;
`endif

  always_comb begin
    sel = 1'b0;
    if (state == LOCKED)
      sel = locked_sel;
    else if (ro_req_i && wo_req_i)
      sel = conflict_pick;
    else
      sel = wo_req_i;
  end

  assign throttled = (count == MAX_CNT);
  assign sel_req   = sel ? wo_req_i : ro_req_i;
  assign l2_req_o  = sys_rst_ni & ~throttled & sel_req;
  assign l2_wen_o  = sel ? wo_wen_i   : ro_wen_i;
  assign l2_addr_o = sel ? wo_addr_i  : ro_addr_i;
  assign l2_be_o   = sel ? wo_be_i    : ro_be_i;
  assign l2_wdata_o = sel ? wo_wdata_i : ro_wdata_i;

  assign grant    = l2_gnt_i & l2_req_o;
  assign ro_gnt_o = grant & ~sel;
  assign wo_gnt_o = grant & sel;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign head        = id_mem[rptr];
  assign pop         = sys_rst_ni & l2_rvalid_i & (count != '0);
  assign ro_rvalid_o = pop & ~head;
  assign wo_rvalid_o = pop & head;
  assign ro_rdata_o  = l2_rdata_i;
  assign wo_rdata_o  = l2_rdata_i;

  assign outstanding_o = count;
  assign err_o         = err;

  // The FSM is frozen while throttled so the lock survives a stall.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_ni) begin
      state      <= IDLE;
      locked_sel <= 1'b0;
    end else if (!throttled) begin
      case (state)
        IDLE: begin
          if (l2_req_o && !l2_gnt_i) begin
            state      <= LOCKED;
            locked_sel <= sel;
          end
        end
        LOCKED: begin
          if (l2_gnt_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_ni) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      err   <= 1'b0;
    end else begin
      if (grant)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (l2_rvalid_i && (count == '0))
        err <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (grant)
      id_mem[wptr] <= sel;
  end

endmodule

// File: tb/tb_pulp_io_l2_arbiter.sv
// Directed bench for pulp_io_l2_arbiter: inputs driven on negedge, outputs sampled 1ns later.
module tb_pulp_io_l2_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ro_req, ro_wen, wo_req, wo_wen;
  logic [31:0] ro_addr, wo_addr, ro_wdata, wo_wdata;
  logic [3:0]  ro_be, wo_be;
  logic        ro_gnt, ro_rvalid, wo_gnt, wo_rvalid;
  logic [31:0] ro_rdata, wo_rdata;
  logic        l2_req, l2_wen, l2_gnt, l2_rvalid;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic [3:0]  l2_be;
  logic [2:0]  outstanding;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulp_io_l2_arbiter dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .ro_req_i(ro_req), .ro_wen_i(ro_wen), .ro_addr_i(ro_addr), .ro_be_i(ro_be),
    .ro_wdata_i(ro_wdata), .ro_gnt_o(ro_gnt), .ro_rvalid_o(ro_rvalid), .ro_rdata_o(ro_rdata),
    .wo_req_i(wo_req), .wo_wen_i(wo_wen), .wo_addr_i(wo_addr), .wo_be_i(wo_be),
    .wo_wdata_i(wo_wdata), .wo_gnt_o(wo_gnt), .wo_rvalid_o(wo_rvalid), .wo_rdata_o(wo_rdata),
    .l2_req_o(l2_req), .l2_wen_o(l2_wen), .l2_addr_o(l2_addr), .l2_be_o(l2_be),
    .l2_wdata_o(l2_wdata), .l2_gnt_i(l2_gnt), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  task automatic drive(input logic rr, input logic wr, input logic g, input logic rv,
                       input logic [31:0] rd);
    @(negedge clk);
    ro_req = rr; wo_req = wr; l2_gnt = g; l2_rvalid = rv; l2_rdata = rd;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; ro_req = 1'b1; wo_req = 1'b1; l2_gnt = 1'b1; l2_rvalid = 1'b1;
    #1;
    total++;
    if ({l2_req, ro_gnt, wo_gnt, ro_rvalid, wo_rvalid, err} !== 6'b0 || outstanding !== 3'd0) begin
      bad++;
      $display("FAIL reset_outputs req/gnts/rvalids/err=%b out=%0d want 000000 out=0",
               {l2_req, ro_gnt, wo_gnt, ro_rvalid, wo_rvalid, err}, outstanding);
    end
    @(negedge clk);
    rst_n = 1'b1; ro_req = 1'b0; wo_req = 1'b0; l2_gnt = 1'b0; l2_rvalid = 1'b0;
    #1;
    total++;
    if (outstanding !== 3'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state out=%0d err=%b want 0 0", outstanding, err);
    end
  endtask

  task automatic test_round_robin;
    logic s;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      s = k[0];
      total++;
      if ({ro_gnt, wo_gnt, l2_req} !== {~s, s, 1'b1}) begin
        bad++;
        $display("FAIL rr_grant[%0d] ro/wo/req=%b want %b", k, {ro_gnt, wo_gnt, l2_req}, {~s, s, 1'b1});
      end
      total++;
      if (l2_addr !== (s ? 32'h2000 : 32'h1000) || l2_wen !== ~s ||
          l2_wdata !== (s ? 32'h2222_2222 : 32'h1111_1111) || l2_be !== (s ? 4'h3 : 4'hF)) begin
        bad++;
        $display("FAIL rr_payload[%0d] addr=%h wen=%b wdata=%h be=%h", k, l2_addr, l2_wen, l2_wdata, l2_be);
      end
      total++;
      if (outstanding !== 3'(k)) begin
        bad++;
        $display("FAIL rr_count[%0d] out=%0d want %0d", k, outstanding, k);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    total++;
    if ({ro_gnt, wo_gnt, l2_req} !== 3'b000 || outstanding !== 3'd4) begin
      bad++;
      $display("FAIL throttle gnts/req=%b out=%0d want 000 out=4", {ro_gnt, wo_gnt, l2_req}, outstanding);
    end
    // Pop while full: still throttled this cycle even with ro requesting.
    for (int j = 0; j < 4; j++) begin
      drive(j == 0, 1'b0, j == 0, 1'b1, 32'hD0 + 32'(j));
      total++;
      if ({ro_rvalid, wo_rvalid, l2_req, ro_gnt} !== {~j[0], j[0], 2'b00} ||
          ro_rdata !== 32'hD0 + 32'(j) || wo_rdata !== 32'hD0 + 32'(j)) begin
        bad++;
        $display("FAIL rr_drain[%0d] rv ro/wo,req,gnt=%b rdata=%h want %b %h", j,
                 {ro_rvalid, wo_rvalid, l2_req, ro_gnt}, ro_rdata, {~j[0], j[0], 2'b00}, 32'hD0 + 32'(j));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (outstanding !== 3'd0) begin
      bad++;
      $display("FAIL rr_empty out=%0d want 0", outstanding);
    end
  endtask

  task automatic test_lock;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);  // leaves rr preferring wo
    total++;
    if ({ro_gnt, wo_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL lock_pre gnts=%b want 10", {ro_gnt, wo_gnt});
    end
    for (int c = 1; c <= 5; c++) begin
      drive(c <= 4, c >= 2, c >= 4, 1'b0, 32'h0);
      total++;
      if ({ro_gnt, wo_gnt, l2_req} !== (c == 5 ? 3'b011 : (c == 4 ? 3'b101 : 3'b001)) ||
          l2_addr !== (c == 5 ? 32'h2000 : 32'h1000)) begin
        bad++;
        $display("FAIL lock_cycle[%0d] ro/wo/req=%b addr=%h", c, {ro_gnt, wo_gnt, l2_req}, l2_addr);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (outstanding !== 3'd3) begin
      bad++;
      $display("FAIL lock_count out=%0d want 3", outstanding);
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h30 + 32'(j));
      total++;
      if ({ro_rvalid, wo_rvalid} !== (j == 2 ? 2'b01 : 2'b10) || ro_rdata !== 32'h30 + 32'(j)) begin
        bad++;
        $display("FAIL lock_resp[%0d] rv=%b rdata=%h", j, {ro_rvalid, wo_rvalid}, ro_rdata);
      end
    end
  endtask

  task automatic test_response_order;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    total++;
    if ({ro_gnt, wo_gnt} !== 2'b10 || outstanding !== 3'd0) begin
      bad++;
      $display("FAIL order_g0 gnts=%b out=%0d want 10 0", {ro_gnt, wo_gnt}, outstanding);
    end
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      total++;
      if ({ro_gnt, wo_gnt} !== 2'b01) begin
        bad++;
        $display("FAIL order_g%0d gnts=%b want 01", j + 1, {ro_gnt, wo_gnt});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hA);
    total++;
    if ({ro_rvalid, wo_rvalid} !== 2'b10 || ro_rdata !== 32'hA || outstanding !== 3'd3) begin
      bad++;
      $display("FAIL order_A rv=%b rdata=%h out=%0d want 10 a 3", {ro_rvalid, wo_rvalid}, ro_rdata, outstanding);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hB);
    total++;
    if ({ro_rvalid, wo_rvalid} !== 2'b01 || wo_rdata !== 32'hB) begin
      bad++;
      $display("FAIL order_B rv=%b rdata=%h want 01 b", {ro_rvalid, wo_rvalid}, wo_rdata);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hC);
    total++;
    if ({ro_rvalid, wo_rvalid} !== 2'b01 || wo_rdata !== 32'hC) begin
      bad++;
      $display("FAIL order_C rv=%b rdata=%h want 01 c", {ro_rvalid, wo_rvalid}, wo_rdata);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (outstanding !== 3'd0) begin
      bad++;
      $display("FAIL order_empty out=%0d want 0", outstanding);
    end
  endtask

  task automatic test_push_pop_wrap;
    for (int j = 0; j < 3; j++) begin
      drive(~j[0], j[0], 1'b1, 1'b0, 32'h0);
      total++;
      if ({ro_gnt, wo_gnt} !== {~j[0], j[0]}) begin
        bad++;
        $display("FAIL wrap_g%0d gnts=%b want %b", j, {ro_gnt, wo_gnt}, {~j[0], j[0]});
      end
    end
    // FIFO holds ro,wo,ro; each combo cycle pops the head and appends a new ID.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h51);
    total++;
    if ({wo_gnt, ro_rvalid, wo_rvalid} !== 3'b110 || ro_rdata !== 32'h51 || outstanding !== 3'd3) begin
      bad++;
      $display("FAIL wrap_combo1 gnt/rv=%b rdata=%h out=%0d want 110 51 3",
               {wo_gnt, ro_rvalid, wo_rvalid}, ro_rdata, outstanding);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h52);
    total++;
    if ({ro_gnt, ro_rvalid, wo_rvalid} !== 3'b101 || wo_rdata !== 32'h52 || outstanding !== 3'd3) begin
      bad++;
      $display("FAIL wrap_combo2 gnt/rv=%b rdata=%h out=%0d want 101 52 3",
               {ro_gnt, ro_rvalid, wo_rvalid}, wo_rdata, outstanding);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (outstanding !== 3'd3) begin
      bad++;
      $display("FAIL wrap_hold out=%0d want 3", outstanding);
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h60 + 32'(j));
      total++;
      if ({ro_rvalid, wo_rvalid} !== {~j[0], j[0]}) begin
        bad++;
        $display("FAIL wrap_drain[%0d] rv=%b want %b", j, {ro_rvalid, wo_rvalid}, {~j[0], j[0]});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (outstanding !== 3'd0) begin
      bad++;
      $display("FAIL wrap_empty out=%0d want 0", outstanding);
    end
  endtask

  task automatic test_error;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hEE);
    total++;
    if ({ro_rvalid, wo_rvalid, err} !== 3'b000) begin
      bad++;
      $display("FAIL err_pulse rv/err=%b want 000", {ro_rvalid, wo_rvalid, err});
    end
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (err !== 1'b1 || outstanding !== 3'd0) begin
        bad++;
        $display("FAIL err_sticky[%0d] err=%b out=%0d want 1 0", j, err, outstanding);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear err=%b want 0", err);
    end
  endtask

`ifdef PULP_IO_L2_ARB_WO_PRIO_EN
  task automatic test_wo_priority;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      total++;
      if ({ro_gnt, wo_gnt} !== 2'b01) begin
        bad++;
        $display("FAIL wo_prio[%0d] gnts=%b want 01", k, {ro_gnt, wo_gnt});
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    ro_req = 1'b0; wo_req = 1'b0; l2_gnt = 1'b0; l2_rvalid = 1'b0; l2_rdata = '0;
    ro_wen = 1'b1; ro_addr = 32'h1000; ro_be = 4'hF; ro_wdata = 32'h1111_1111;
    wo_wen = 1'b0; wo_addr = 32'h2000; wo_be = 4'h3; wo_wdata = 32'h2222_2222;
    test_reset();
`ifdef PULP_IO_L2_ARB_WO_PRIO_EN
    test_wo_priority();
`else
    test_round_robin();
    test_lock();
    test_response_order();
    test_push_pop_wrap();
    test_error();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulp_io_l2_arbiter.md
Name: pulp_io_l2_arbiter

Overview:
- Merges the uDMA read-only (ro) and write-only (wo) L2 ports onto one L2 master port (req/gnt/rvalid, in-order responses).
- Round-robin arbitration between the two ports.
- Locks the arbiter's choice until the L2 side grants it.
- Tracks outstanding transactions in an ID FIFO so each rvalid/rdata goes back to the port that issued it.
- Sits between the uDMA subsystem and the SoC L2 interconnect when the SoC exposes only a single L2 port for IO.

Parameters:
- L2_DATA_WIDTH, 32, data width of all ports; byte enables are L2_DATA_WIDTH/8 bits.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions; power of two, >=2.

Ports:
- sys_clk_i  in  1  clock
- sys_rst_ni  in  1  synchronous active-low reset
- ro_req_i  in  1  ro port request
- ro_wen_i  in  1  ro write-enable, active-low (1 = read)
- ro_addr_i  in  32  ro address
- ro_be_i  in  L2_DATA_WIDTH/8  ro byte enables
- ro_wdata_i  in  L2_DATA_WIDTH  ro write data
- ro_gnt_o  out  1  ro grant
- ro_rvalid_o  out  1  ro response valid
- ro_rdata_o  out  L2_DATA_WIDTH  ro response data
- wo_req_i, wo_wen_i, wo_addr_i, wo_be_i, wo_wdata_i, wo_gnt_o, wo_rvalid_o, wo_rdata_o  as the ro set, for the wo port
- l2_req_o  out  1  master request
- l2_wen_o  out  1  master write-enable, active-low
- l2_addr_o  out  32  master address
- l2_be_o  out  L2_DATA_WIDTH/8  master byte enables
- l2_wdata_o  out  L2_DATA_WIDTH  master write data
- l2_gnt_i  in  1  master grant
- l2_rvalid_i  in  1  master response valid
- l2_rdata_i  in  L2_DATA_WIDTH  master response data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current outstanding count
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (sys_rst_ni low at a rising edge) clears:
  - outstanding count to 0 and the ID FIFO to empty;
  - rr pointer to "ro preferred";
  - lock state to IDLE;
  - err_o to 0.
- Output values while in reset:
  - l2_req_o, ro_gnt_o, wo_gnt_o, ro_rvalid_o, wo_rvalid_o = 0;
  - outstanding_o = 0, err_o = 0.
- Reset mid-transaction drops all tracking; the L2 side is reset together with this block.
- Arbitration FSM, states IDLE and LOCKED:
  - IDLE: choose a requester.
    - Only one requesting: choose it.
    - Both requesting: choose the one the rr pointer prefers.
    - Request to L2 is combinational: l2_req_o, l2_wen_o, l2_addr_o, l2_be_o and l2_wdata_o follow the chosen port in the same cycle (0 cycles added latency).
    - If l2_gnt_i = 0, go to LOCKED and register the chosen port.
  - LOCKED: the registered port stays selected regardless of the other request or the rr pointer; return to IDLE on l2_gnt_i.
  - Requesters must hold req and payload stable until gnt (uDMA rule); the arbiter does not check this.
- Grant path:
  - chosen_gnt_o = l2_gnt_i & l2_req_o; the other port's gnt = 0.
  - On a grant, the rr pointer flips to prefer the other port.
  - On a grant, push the port ID (0 = ro, 1 = wo) into the ID FIFO.
- Throttling:
  - While outstanding == MAX_OUTSTANDING (registered value), l2_req_o = 0 and both gnts = 0.
  - A pop in that same cycle does not unthrottle it; the next cycle does.
  - FSM state does not change while throttled.
- Response path:
  - l2_rvalid_i pops the FIFO head.
  - Head ID selects which port gets rvalid; rdata goes combinationally to both ports; only the selected port sees rvalid = 1.
  - Responses arrive at least 1 cycle after their grant, strictly in order.
- Simultaneous grant and rvalid: push and pop in the same cycle, count unchanged; FIFO pointers wrap modulo MAX_OUTSTANDING.
- l2_rvalid_i while the FIFO is empty:
  - no pop and no rvalid forwarded to either port;
  - err_o set to 1 and held until reset.
- Writes also return an rvalid (L2 protocol) and are routed identically.
- outstanding_o shows the registered count: range 0..MAX_OUTSTANDING; +1 per grant, -1 per pop, net 0 when both happen.

Optional Feature:
- Macro PULP_IO_L2_ARB_WO_PRIO_EN.
- Defined:
  - fixed priority; wo wins every IDLE conflict;
  - rr pointer not implemented;
  - LOCKED hold and throttling unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then ro_req_i = 1 and wo_req_i = 1 with l2_gnt_i tied 1 for 4 cycles → grants alternate ro, wo, ro, wo; l2_addr_o follows the granted port each cycle; outstanding_o = 4; both gnts 0 in cycle 5.
- ro_req_i = 1, l2_gnt_i = 0 for 3 cycles, wo_req_i rises in cycle 2, l2_gnt_i = 1 in cycle 4 → l2_addr_o stays ro_addr_i through cycle 4; ro_gnt_o = 1 only in cycle 4; wo granted in cycle 5.
- Grants in order ro, wo, wo, then three rvalids with rdata 0xA, 0xB, 0xC → ro_rvalid_o with 0xA, then wo_rvalid_o with 0xB and 0xC; outstanding_o returns to 0.
- Hold outstanding at 3, then grant and rvalid in the same cycle → outstanding_o stays 3; the head ID pops and the new ID is appended; FIFO ordering is correct across pointer wrap.
- l2_rvalid_i pulse with outstanding_o = 0 → err_o = 1 from the next cycle and stays 1; no port rvalid; err_o = 0 after sys_rst_ni low for one edge.
- With PULP_IO_L2_ARB_WO_PRIO_EN defined, both requesting and gnt tied 1 for 3 cycles → wo_gnt_o = 1 every cycle, ro_gnt_o = 0.
